// File: rtl/clint_pkg.sv
// Shared types and default widths for the CLINT register-port arbiter.
package clint_pkg;

  localparam int unsigned ClintAddrWidth = 64;
  localparam int unsigned ClintDataWidth = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req at or above ptr, with wrap.
module rr_pick #(
  parameter int unsigned NumReq = 2,
  parameter int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic [NumReq-1:0] req,
  input  logic [IdxW-1:0]   ptr,
  output logic [IdxW-1:0]   winner,
  output logic              any_valid
);

  logic [NumReq-1:0] rot;
  logic [IdxW-1:0]   off;

  // Rotate so ptr sits at bit 0, find the lowest set bit, then rotate the index back.
  always_comb begin
    rot       = '0;
    off       = '0;
    any_valid = 1'b0;
    for (int i = 0; i < int'(NumReq); i++)
      rot[i] = req[(i + int'(ptr)) % int'(NumReq)];
    for (int i = int'(NumReq) - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off       = IdxW'(i);
        any_valid = 1'b1;
      end
    end
    winner = IdxW'((int'(off) + int'(ptr)) % int'(NumReq));
  end

endmodule

// File: rtl/clint_reg_arbiter.sv
// Shares one CLINT register port between NumReq requesters, one transaction at a time:
// accept -> one-cycle issue -> held response until the owner takes it.
module clint_reg_arbiter
  import clint_pkg::*;
#(
  parameter int unsigned NumReq    = 2,
  parameter int unsigned AddrWidth = ClintAddrWidth,
  parameter int unsigned DataWidth = ClintDataWidth
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NumReq-1:0]             req_valid_i,
  output logic [NumReq-1:0]             req_ready_o,
  input  logic [NumReq-1:0]             req_we_i,
  input  logic [NumReq*AddrWidth-1:0]   req_addr_i,
  input  logic [NumReq*DataWidth-1:0]   req_wdata_i,
  output logic [NumReq-1:0]             rsp_valid_o,
  input  logic [NumReq-1:0]             rsp_ready_i,
  output logic [DataWidth-1:0]          rsp_rdata_o,
  output logic [AddrWidth-1:0]          address_o,
  output logic                          en_o,
  output logic                          we_o,
  output logic [DataWidth-1:0]          data_o,
  input  logic [DataWidth-1:0]          data_i
);

  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

  arb_state_e            state_q, state_d;
  logic [IdxW-1:0]       rr_ptr_q, idx_q, winner, next_ptr;
  logic                  any_valid, accept, we_q;
  logic [AddrWidth-1:0]  addr_q;
  logic [DataWidth-1:0]  wdata_q, rdata_q;

  rr_pick #(.NumReq(NumReq), .IdxW(IdxW)) u_pick (
    .req       (req_valid_i),
    .ptr       (rr_ptr_q),
    .winner    (winner),
    .any_valid (any_valid)
  );

  assign accept   = (state_q == IDLE) && any_valid;
  assign next_ptr = IdxW'((int'(winner) + 1) % int'(NumReq));

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_valid) state_d = ISSUE;
      ISSUE:   state_d = RESP;
      RESP:    if (rsp_ready_i[idx_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Payload is sampled only at accept; the requester holds it stable until then.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q <= '0;
      idx_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      if (accept) begin
        rr_ptr_q <= next_ptr;
        idx_q    <= winner;
        we_q     <= req_we_i[winner];
        addr_q   <= req_addr_i[winner*AddrWidth +: AddrWidth];
        wdata_q  <= req_wdata_i[winner*DataWidth +: DataWidth];
      end
      if (state_q == ISSUE) rdata_q <= we_q ? '0 : data_i;
    end
  end

  // Everything is forced quiet while reset is asserted, even mid-transaction.
  always_comb begin
    req_ready_o = '0;
    rsp_valid_o = '0;
    rsp_rdata_o = '0;
    en_o        = 1'b0;
    we_o        = 1'b0;
    address_o   = '0;
    data_o      = '0;
    if (!rst_i) begin
      unique case (state_q)
        IDLE:    if (any_valid) req_ready_o[winner] = 1'b1;
        ISSUE: begin
          en_o      = 1'b1;
          we_o      = we_q;
          address_o = addr_q;
          data_o    = wdata_q;
        end
        RESP: begin
          rsp_valid_o[idx_q] = 1'b1;
          rsp_rdata_o        = rdata_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_clint_reg_arbiter.sv
// Directed + randomized checks of clint_reg_arbiter (NumReq=2 and NumReq=3 instances).
module tb_clint_reg_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // NumReq=2 instance
  logic [1:0]   valid2 = '0, ready2, we2 = '0, rsp_valid2, rsp_ready2 = 2'b11;
  logic [127:0] addr2 = '0, wdata2 = '0;
  logic [63:0]  rdata2, address2, data_o2, data_i2;
  logic         en2, we_o2;

  // NumReq=3 instance
  logic [2:0]   valid3 = '0, ready3, we3 = '0, rsp_valid3, rsp_ready3 = 3'b111;
  logic [191:0] addr3 = '0, wdata3 = '0;
  logic [63:0]  rdata3, address3, data_o3, data_i3;
  logic         en3, we_o3;

  int n_checks = 0;
  int n_fail   = 0;

  // Register file stand-in: read data is a fixed function of the address.
  function automatic logic [63:0] hmem(input logic [63:0] a);
    if (a == 64'h4000) return 64'hDEAD_BEEF;
    return {a[31:0], a[63:32]} ^ 64'h5A5A_C3C3_0F0F_9696;
  endfunction

  assign data_i2 = hmem(address2);
  assign data_i3 = hmem(address3);

  clint_reg_arbiter #(.NumReq(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(valid2), .req_ready_o(ready2), .req_we_i(we2),
    .req_addr_i(addr2), .req_wdata_i(wdata2), .rsp_valid_o(rsp_valid2), .rsp_ready_i(rsp_ready2),
    .rsp_rdata_o(rdata2), .address_o(address2), .en_o(en2), .we_o(we_o2), .data_o(data_o2),
    .data_i(data_i2)
  );

  clint_reg_arbiter #(.NumReq(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(valid3), .req_ready_o(ready3), .req_we_i(we3),
    .req_addr_i(addr3), .req_wdata_i(wdata3), .rsp_valid_o(rsp_valid3), .rsp_ready_i(rsp_ready3),
    .rsp_rdata_o(rdata3), .address_o(address3), .en_o(en3), .we_o(we_o3), .data_o(data_o3),
    .data_i(data_i3)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model for the random phase: requesters hold payloads until granted,
  // grant goes to the first valid requester at or after the pointer, then one issue
  // cycle, then the response until its owner is ready.
  bit          pv[2];
  bit          pwe[2];
  logic [63:0] paddr[2], pwd[2];
  int          ptr_m = 0;
  int          age   = 0;   // 0 idle, 1 issue cycle, 2 response pending
  int          t_idx;
  bit          t_we;
  logic [63:0] t_addr, t_wd;

  task automatic rand_cycle(input bit gen);
    int win, k, age_n;
    logic [1:0] exp_ready;
    for (int r = 0; r < 2; r++) begin
      if (!pv[r] && gen && ($urandom_range(1, 0) == 1)) begin
        pv[r]    = 1'b1;
        pwe[r]   = bit'($urandom_range(1, 0));
        paddr[r] = {$urandom, $urandom};
        pwd[r]   = {$urandom, $urandom};
      end
      valid2[r]          = pv[r];
      we2[r]             = pwe[r];
      addr2[r*64 +: 64]  = paddr[r];
      wdata2[r*64 +: 64] = pwd[r];
    end
    rsp_ready2 = gen ? 2'($urandom_range(3, 0)) : 2'b11;
    #1;
    win = -1;
    for (int d = 0; d < 2; d++) begin
      k = (ptr_m + d) % 2;
      if (pv[k] && win < 0) win = k;
    end
    exp_ready = (age == 0 && win >= 0) ? 2'(1 << win) : 2'b00;
    chk("rnd_req_ready", 64'(ready2), 64'(exp_ready));
    if (age == 1) begin
      chk("rnd_en", 64'(en2), 64'd1);
      chk("rnd_we", 64'(we_o2), 64'(t_we));
      chk("rnd_addr", address2, t_addr);
      chk("rnd_wdata", data_o2, t_wd);
    end else begin
      chk("rnd_en_idle", 64'(en2), 64'd0);
      chk("rnd_addr_idle", address2, 64'd0);
    end
    if (age == 2) begin
      chk("rnd_rsp_valid", 64'(rsp_valid2), 64'(1 << t_idx));
      chk("rnd_rdata", rdata2, t_we ? 64'd0 : hmem(t_addr));
    end else
      chk("rnd_rsp_idle", 64'(rsp_valid2), 64'd0);
    age_n = age;
    if (age == 0 && win >= 0) begin
      t_idx = win; t_we = pwe[win]; t_addr = paddr[win]; t_wd = pwd[win];
      pv[win] = 1'b0;
      ptr_m   = (win + 1) % 2;
      age_n   = 1;
    end else if (age == 1)
      age_n = 2;
    else if (age == 2 && rsp_ready2[t_idx])
      age_n = 0;
    tick();
    age = age_n;
  endtask

  initial begin
    logic [63:0] held;
    int guard;
    #1;
    // Reset: outputs quiet even with requests present
    valid2 = 2'b11;
    tick();
    chk("rst_req_ready", 64'(ready2), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid2), 64'd0);
    chk("rst_en", 64'(en2), 64'd0);
    chk("rst_rdata", rdata2, 64'd0);
    valid2 = 2'b00;
    rst = 1'b0;
    tick();

    // Single read from r0
    valid2 = 2'b01; we2 = 2'b00; addr2[63:0] = 64'h4000;
    #1 chk("rd_ready", 64'(ready2), 64'd1);
    tick();
    valid2 = 2'b00;
    chk("rd_en", 64'(en2), 64'd1);
    chk("rd_we", 64'(we_o2), 64'd0);
    chk("rd_addr", address2, 64'h4000);
    tick();
    chk("rd_rsp_valid", 64'(rsp_valid2), 64'd1);
    chk("rd_rdata", rdata2, 64'hDEAD_BEEF);
    chk("rd_en_off", 64'(en2), 64'd0);
    tick();

    // Single write from r1
    valid2 = 2'b10; we2 = 2'b10; addr2[127:64] = 64'hBFF8; wdata2[127:64] = 64'h1234;
    #1 chk("wr_ready", 64'(ready2), 64'd2);
    tick();
    valid2 = 2'b00;
    chk("wr_en", 64'(en2), 64'd1);
    chk("wr_we", 64'(we_o2), 64'd1);
    chk("wr_addr", address2, 64'hBFF8);
    chk("wr_data", data_o2, 64'h1234);
    tick();
    chk("wr_rsp_valid", 64'(rsp_valid2), 64'd2);
    chk("wr_rdata", rdata2, 64'd0);
    tick();

    // Both valid continuously: r0, r1, r0, r1
    valid2 = 2'b11; we2 = 2'b00;
    for (int t = 0; t < 4; t++) begin
      #1 chk("rr_grant", 64'(ready2), (t % 2 == 0) ? 64'd1 : 64'd2);
      tick();
      chk("rr_ready_busy1", 64'(ready2), 64'd0);
      tick();
      chk("rr_ready_busy2", 64'(ready2), 64'd0);
      tick();
    end
    valid2 = 2'b00;

    // Response backpressure on r0; r1's ready must not release it
    valid2 = 2'b01; addr2[63:0] = 64'h100; rsp_ready2 = 2'b10;
    #1 chk("bp_ready", 64'(ready2), 64'd1);
    tick();
    valid2 = 2'b00;
    tick();
    held = hmem(64'h100);
    valid2 = 2'b11;
    for (int t = 0; t < 5; t++) begin
      chk("bp_rsp_valid", 64'(rsp_valid2), 64'd1);
      chk("bp_rdata", rdata2, held);
      chk("bp_no_grant", 64'(ready2), 64'd0);
      chk("bp_en", 64'(en2), 64'd0);
      tick();
    end
    rsp_ready2 = 2'b01;
    #1 chk("bp_release", 64'(rsp_valid2), 64'd1);
    tick();
    chk("bp_next_grant", 64'(ready2), 64'd2);
    valid2 = 2'b00; rsp_ready2 = 2'b11;
    tick();

    // Reset during ISSUE drops the transaction and clears the pointer
    valid2 = 2'b01;
    tick();
    valid2 = 2'b00;
    rst = 1'b1;
    #1 chk("rsti_en_in_reset", 64'(en2), 64'd0);
    tick();
    rst = 1'b0;
    chk("rsti_en", 64'(en2), 64'd0);
    chk("rsti_rsp", 64'(rsp_valid2), 64'd0);
    valid2 = 2'b11;
    #1 chk("rsti_ptr0", 64'(ready2), 64'd1);
    valid2 = 2'b10; we2 = 2'b10; addr2[127:64] = 64'h8; wdata2[127:64] = 64'h77;
    #1 chk("rsti_r1_ready", 64'(ready2), 64'd2);
    tick();
    valid2 = 2'b00;
    chk("rsti_r1_en", 64'(en2), 64'd1);
    chk("rsti_r1_addr", address2, 64'h8);
    tick();
    chk("rsti_r1_rsp", 64'(rsp_valid2), 64'd2);
    tick();

    // Randomized traffic against the model (pointer is 0 after the r1 grant)
    ptr_m = 0; age = 0;
    for (int r = 0; r < 2; r++) pv[r] = 1'b0;
    for (int c = 0; c < 300; c++) rand_cycle(1'b1);
    guard = 0;
    while ((age != 0 || pv[0] || pv[1]) && guard < 40) begin
      rand_cycle(1'b0);
      guard++;
    end
    chk("rnd_drained", 64'(guard < 40), 64'd1);
    valid2 = 2'b00;

    // NumReq=3: r2 alone, pointer wraps to 0, then r0 wins over r1
    valid3 = 3'b100; we3 = 3'b000; addr3[191:128] = 64'h4000;
    #1 chk("n3_r2_ready", 64'(ready3), 64'd4);
    tick();
    valid3 = 3'b000;
    chk("n3_en", 64'(en3), 64'd1);
    chk("n3_addr", address3, 64'h4000);
    tick();
    chk("n3_rsp_valid", 64'(rsp_valid3), 64'd4);
    chk("n3_rdata", rdata3, 64'hDEAD_BEEF);
    tick();
    valid3 = 3'b011; addr3[63:0] = 64'h20;
    #1 chk("n3_wrap_r0", 64'(ready3), 64'd1);
    tick();
    valid3 = 3'b000;
    chk("n3_r0_addr", address3, 64'h20);
    tick();
    chk("n3_r0_rsp", 64'(rsp_valid3), 64'd1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
